ms_deadline: RTL and testbench

Millisecond countdown deadline generator for the ESP8266 Wi-Fi link controller. It is the complement of the free-running elapsed-time counter: it generates a timeout instead of measuring one. The controller loads a timeout in milliseconds and pulses `start`. The block prescales the system clock to 1 ms ticks, counts down, and flags expiry so the controller can abort or retry a send/receive exchange.

---
 rtl/ms_deadline.sv | 148 ++++++++++++++
 tb/tb_ms_deadline.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ms_deadline.sv
// ----------------------------------------------------------------------------
// ms_deadline
//
// Millisecond countdown deadline generator. The link controller loads a
// timeout in milliseconds and pulses i_start. The block divides the system
// clock down to 1 ms ticks with an internal prescaler. It counts the loaded
// value down to zero and then flags expiry, so the controller can abort or
// retry an exchange.
//
// Parameters
//   PERIOD        clock cycles per 1 ms tick (1 .. 2^20-1), default 50000
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_start       load i_timeout_ms and (re)start the countdown
//   i_cancel      abort a running countdown; no expiry is signalled
//   i_timeout_ms  deadline in ms, sampled only on an edge with i_start=1
//   o_busy        countdown in progress
//   o_expired     deadline reached
//   o_remaining   whole milliseconds left, 0 when idle
//
// Build option
//   MS_DEADLINE_STICKY_EN  when defined, o_expired is sticky. It stays set
//                          until the next start/cancel edge or reset. When
//                          not defined, o_expired is a one-cycle pulse.
//
// Event priority on each edge: start > cancel > prescaler tick.
// ----------------------------------------------------------------------------
module ms_deadline #(
  parameter int unsigned PERIOD = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_cancel,
  input  logic [15:0] i_timeout_ms,
  output logic        o_busy,
  output logic        o_expired,
  output logic [15:0] o_remaining
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [19:0] PRE_LAST = 20'(PERIOD - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [19:0] r_pre;
  logic [19:0] w_pre_next;
  logic [15:0] r_remaining;
  logic [15:0] w_remaining_next;
  logic        r_busy;
  logic        r_expired;
  logic        w_expired_next;
  logic        w_expired_hold;
  logic        w_tick;
  logic        w_zero_load;

  // The value o_expired takes when nothing on this edge sets or clears it.
`ifdef MS_DEADLINE_STICKY_EN
  assign w_expired_hold = r_expired;
`else
  assign w_expired_hold = 1'b0;
`endif

  // With PERIOD=1, PRE_LAST is 0. The prescaler then stays at 0 and every
  // RUN cycle is a tick.
  assign w_tick      = (r_state == ST_RUN) && (r_pre == PRE_LAST);
  assign w_zero_load = (i_timeout_ms == 16'd0);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_pre       <= 20'd0;
      r_remaining <= 16'd0;
      r_busy      <= 1'b0;
      r_expired   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pre       <= w_pre_next;
      r_remaining <= w_remaining_next;
      r_busy      <= (w_state_next == ST_RUN);
      r_expired   <= w_expired_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_pre_next       = r_pre;
    w_remaining_next = r_remaining;
    w_expired_next   = w_expired_hold;

    if (i_start) begin
      // A start edge always begins a fresh deadline. It restarts the
      // prescaler and discards any tick that falls on this edge.
      w_pre_next = 20'd0;
      if (w_zero_load) begin
        // A zero-length deadline expires on the start edge itself and
        // never enters RUN.
        w_state_next     = ST_IDLE;
        w_remaining_next = 16'd0;
        w_expired_next   = 1'b1;
      end else begin
        w_state_next     = ST_RUN;
        w_remaining_next = i_timeout_ms;
        w_expired_next   = 1'b0;
      end
    end else if (i_cancel) begin
      // In RUN, cancel returns to IDLE. In IDLE the state is already idle,
      // so cancel leaves the countdown alone. In both cases it clears a
      // sticky expiry flag.
      w_state_next     = ST_IDLE;
      w_pre_next       = 20'd0;
      w_remaining_next = 16'd0;
      w_expired_next   = 1'b0;
    end else if (r_state == ST_RUN) begin
      if (w_tick) begin
        w_pre_next = 20'd0;
        if (r_remaining <= 16'd1) begin
          // The last millisecond has elapsed. The guard also covers 0, so
          // the count can never wrap.
          w_state_next     = ST_IDLE;
          w_remaining_next = 16'd0;
          w_expired_next   = 1'b1;
        end else begin
          w_remaining_next = r_remaining - 16'd1;
        end
      end else begin
        w_pre_next = r_pre + 20'd1;
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_expired   = r_expired;
  assign o_remaining = r_remaining;

endmodule

// File: tb/tb_ms_deadline.sv
// ----------------------------------------------------------------------------
// tb_ms_deadline
//
// Self-checking bench for ms_deadline, with PERIOD=4. The bench keeps a
// reference model of each deadline: the edge at which it started and its
// length. Expected outputs come from elapsed-cycle arithmetic. The bench
// runs directed scenarios first, then random start/cancel/reset traffic.
// Compile with +define+MS_DEADLINE_STICKY_EN to model the sticky build.
// ----------------------------------------------------------------------------
module tb_ms_deadline;

  localparam int unsigned PERIOD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [15:0] tmo = 16'd0;
  logic        busy;
  logic        expired;
  logic [15:0] remaining;

  ms_deadline #(.PERIOD(PERIOD)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_cancel     (cancel),
    .i_timeout_ms (tmo),
    .o_busy       (busy),
    .o_expired    (expired),
    .o_remaining  (remaining)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a deadline is "running since edge m_t0, m_tmo ms long".
  bit m_run  = 1'b0;
  int m_t0   = 0;
  int m_tmo  = 0;
  bit m_exp  = 1'b0;
  int edge_n = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge(input bit s, input bit c, input int t);
`ifndef MS_DEADLINE_STICKY_EN
    m_exp = 1'b0;
`endif
    if (s) begin
      if (t > 0) begin
        m_run = 1'b1;
        m_t0  = edge_n;
        m_tmo = t;
        m_exp = 1'b0;
      end else begin
        m_run = 1'b0;
        m_exp = 1'b1;
      end
    end else if (c) begin
      m_run = 1'b0;
      m_exp = 1'b0;
    end else if (m_run && (edge_n - m_t0) == m_tmo * int'(PERIOD)) begin
      m_run = 1'b0;
      m_exp = 1'b1;
    end
  endfunction

  function automatic int model_rem();
    if (!m_run) return 0;
    return m_tmo - (edge_n - m_t0) / int'(PERIOD);
  endfunction

  task automatic check_outputs();
    check_val("busy", 32'(busy), 32'(m_run));
    check_val("expired", 32'(expired), 32'(m_exp));
    check_val("remaining", 32'(remaining), 32'(model_rem()));
  endtask

  // Apply one cycle of inputs, advance the model at the edge, and check the
  // outputs on the following falling edge.
  task automatic cyc(input bit s, input bit c, input int t);
    start  = s;
    cancel = c;
    tmo    = 16'(t);
    if (s || c)
      $display("txn edge=%0d start=%0b cancel=%0b timeout_ms=%0d", edge_n, s, c, t);
    @(posedge clk);
    model_edge(s, c, t);
    @(negedge clk);
    check_outputs();
    edge_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0);
  endtask

  // Assert reset between edges and check that the outputs clear before any
  // clock edge arrives.
  task automatic async_reset();
    $display("txn edge=%0d async reset", edge_n);
    #2;
    rst_n = 1'b0;
    #1;
    m_run = 1'b0;
    m_exp = 1'b0;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_expired", 32'(expired), 32'd0);
    check_val("rst_remaining", 32'(remaining), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Check the reset state, then release reset at a falling edge.
    @(negedge clk);
    @(negedge clk);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_expired", 32'(expired), 32'd0);
    check_val("reset_remaining", 32'(remaining), 32'd0);
    rst_n = 1'b1;

    // Basic countdown: 3 ms.
    cyc(1, 0, 3);  idle(14);
    // Zero timeout.
    cyc(1, 0, 0);  idle(3);
    // Cancel mid-run, then cancel on the exact expiry edge.
    cyc(1, 0, 5);  idle(6);  cyc(0, 1, 0); idle(3);
    cyc(1, 0, 5);  idle(19); cyc(0, 1, 0); idle(3);
    // Cancel while idle has no effect.
    cyc(0, 1, 0);  idle(2);
    // Restart mid-run.
    cyc(1, 0, 4);  idle(8);  cyc(1, 0, 2); idle(10);
    // Start on the exact expiry edge.
    cyc(1, 0, 2);  idle(7);  cyc(1, 0, 1); idle(6);
    // Async reset mid-run, then a short deadline.
    cyc(1, 0, 5);  idle(5);  async_reset(); cyc(1, 0, 1); idle(6);
    // Expiry followed by a later start (exercises the sticky build too).
    cyc(1, 0, 1);  idle(12); cyc(1, 0, 2); idle(10);
    // A zero start right after expiry.
    cyc(1, 0, 1);  idle(4);  cyc(1, 0, 0); idle(3);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      bit s;
      bit c;
      int t;
      s = ($urandom_range(0, 15) == 0);
      c = ($urandom_range(0, 24) == 0);
      t = $urandom_range(0, 6);
      if ($urandom_range(0, 299) == 0) async_reset();
      else cyc(s, c, t);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
